// File: rtl/pu_da_dtlb_ctrl.sv
// rtl/pu_da_dtlb_ctrl.sv - DTLB port arbiter for DA-stage lookups and CP0 write/probe/flush
module pu_da_dtlb_ctrl #(
    parameter int TAG_W      = 20,
    parameter int ENTRY_NUM  = 8,
    parameter int IDX_W      = 3,
    parameter int STARVE_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             on,
    input  logic             hw_req,
    input  logic [TAG_W-1:0] hw_vtag,
    output logic             hw_gnt,
    output logic             hw_done,
    output logic [TAG_W-1:0] hw_ptag,
    output logic             hw_nc,
    output logic             hw_miss,
    input  logic             sw_req,
    input  logic [1:0]       sw_op,
    input  logic [IDX_W-1:0] sw_idx,
    input  logic [TAG_W-1:0] sw_vtag,
    input  logic [TAG_W-1:0] sw_ptag,
    input  logic             sw_nc,
    output logic             sw_gnt,
    output logic             sw_done,
    output logic             sw_probe_hit,
    output logic [IDX_W-1:0] sw_probe_idx,
    output logic             tlb_en,
    output logic [TAG_W-1:0] tlb_vtag,
    input  logic [TAG_W-1:0] tlb_ptag,
    input  logic             tlb_hit,
    input  logic [IDX_W-1:0] tlb_hit_idx,
    input  logic             tlb_nc,
    output logic             tlb_we,
    output logic [IDX_W-1:0] tlb_widx,
    output logic [TAG_W-1:0] tlb_wvtag,
    output logic [TAG_W-1:0] tlb_wptag,
    output logic             tlb_wnc,
    output logic             tlb_wvalid
);
    localparam int              SC_W     = $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0] SC_MAX   = SC_W'(STARVE_MAX);
    localparam logic [IDX_W-1:0] WALK_END = IDX_W'(ENTRY_NUM - 1);
    localparam logic [1:0]      OP_WRITE = 2'b00;
    localparam logic [1:0]      OP_PROBE = 2'b01;
    localparam logic [1:0]      OP_FLUSH = 2'b10;

    typedef enum logic {S_IDLE, S_FLUSH} state_t;

    state_t           state, state_nxt;
    logic [SC_W-1:0]  starve;
    logic [IDX_W-1:0] walk;
    logic             pend_hw, pend_byp, pend_sw, pend_probe;
    logic [TAG_W-1:0] byp_tag;
    logic             starved, flush_start, walk_last;

    assign starved     = (starve == SC_MAX);
    assign flush_start = sw_gnt && (sw_op == OP_FLUSH);
    assign walk_last   = (state == S_FLUSH) && (walk == WALK_END);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (flush_start) state_nxt = S_FLUSH;
            S_FLUSH: if (walk_last)   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Grants and array strobes are gated by rst so a reset cycle drives nothing,
    // which is what aborts a flush walk on the spot.
    always_comb begin
        hw_gnt     = 1'b0;
        sw_gnt     = 1'b0;
        tlb_en     = 1'b0;
        tlb_vtag   = '0;
        tlb_we     = 1'b0;
        tlb_widx   = '0;
        tlb_wvtag  = '0;
        tlb_wptag  = '0;
        tlb_wnc    = 1'b0;
        tlb_wvalid = 1'b0;
        if (!rst && state == S_IDLE) begin
            hw_gnt = hw_req && !(sw_req && starved);
            sw_gnt = sw_req && !hw_gnt;
        end
        if (hw_gnt && on) begin
            tlb_en   = 1'b1;
            tlb_vtag = hw_vtag;
        end
        if (sw_gnt) begin
            case (sw_op)
                OP_WRITE: begin
                    tlb_we     = 1'b1;
                    tlb_widx   = sw_idx;
                    tlb_wvtag  = sw_vtag;
                    tlb_wptag  = sw_ptag;
                    tlb_wnc    = sw_nc;
                    tlb_wvalid = 1'b1;
                end
                OP_PROBE: begin
                    tlb_en   = 1'b1;
                    tlb_vtag = sw_vtag;
                end
                OP_FLUSH: begin
                    tlb_we   = 1'b1;
                    tlb_widx = walk;
                end
                default: ;
            endcase
        end
        if (!rst && state == S_FLUSH) begin
            tlb_we   = 1'b1;
            tlb_widx = walk;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_hw    <= 1'b0;
            pend_byp   <= 1'b0;
            byp_tag    <= '0;
            pend_sw    <= 1'b0;
            pend_probe <= 1'b0;
            walk       <= '0;
            starve     <= '0;
        end else begin
            pend_hw    <= hw_gnt;
            pend_byp   <= hw_gnt && !on;
            byp_tag    <= (hw_gnt && !on) ? hw_vtag : '0;
            pend_sw    <= (sw_gnt && sw_op != OP_FLUSH) || walk_last;
            pend_probe <= sw_gnt && (sw_op == OP_PROBE);
            if (flush_start || state == S_FLUSH)
                walk <= (walk == WALK_END) ? '0 : walk + 1'b1;
            if (!sw_req || sw_gnt)
                starve <= '0;
            else if (!starved)
                starve <= starve + 1'b1;
        end
    end

    assign hw_done      = pend_hw;
    assign hw_ptag      = pend_byp ? byp_tag : (pend_hw ? tlb_ptag : '0);
    assign hw_nc        = pend_hw && !pend_byp && tlb_nc;
    assign hw_miss      = pend_hw && !pend_byp && !tlb_hit;
    assign sw_done      = pend_sw;
    assign sw_probe_hit = pend_probe && tlb_hit;
    assign sw_probe_idx = pend_probe ? tlb_hit_idx : '0;
endmodule

// File: tb/tb_pu_da_dtlb_ctrl.sv
// tb/tb_pu_da_dtlb_ctrl.sv - scoreboard bench for pu_da_dtlb_ctrl with a behavioural DTLB model
module tb_pu_da_dtlb_ctrl;
    localparam int TAG_W = 20, EN = 8, IDX_W = 3, SMAX = 8;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic             on, hw_req, hw_gnt, hw_done, hw_nc, hw_miss;
    logic [TAG_W-1:0] hw_vtag, hw_ptag;
    logic             sw_req, sw_nc, sw_gnt, sw_done, sw_probe_hit;
    logic [1:0]       sw_op;
    logic [IDX_W-1:0] sw_idx, sw_probe_idx;
    logic [TAG_W-1:0] sw_vtag, sw_ptag;
    logic             tlb_en, tlb_hit, tlb_nc, tlb_we, tlb_wnc, tlb_wvalid;
    logic [TAG_W-1:0] tlb_vtag, tlb_ptag, tlb_wvtag, tlb_wptag;
    logic [IDX_W-1:0] tlb_hit_idx, tlb_widx;

    pu_da_dtlb_ctrl #(.TAG_W(TAG_W), .ENTRY_NUM(EN), .IDX_W(IDX_W), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst), .on(on),
        .hw_req(hw_req), .hw_vtag(hw_vtag), .hw_gnt(hw_gnt), .hw_done(hw_done),
        .hw_ptag(hw_ptag), .hw_nc(hw_nc), .hw_miss(hw_miss),
        .sw_req(sw_req), .sw_op(sw_op), .sw_idx(sw_idx), .sw_vtag(sw_vtag),
        .sw_ptag(sw_ptag), .sw_nc(sw_nc), .sw_gnt(sw_gnt), .sw_done(sw_done),
        .sw_probe_hit(sw_probe_hit), .sw_probe_idx(sw_probe_idx),
        .tlb_en(tlb_en), .tlb_vtag(tlb_vtag), .tlb_ptag(tlb_ptag), .tlb_hit(tlb_hit),
        .tlb_hit_idx(tlb_hit_idx), .tlb_nc(tlb_nc), .tlb_we(tlb_we), .tlb_widx(tlb_widx),
        .tlb_wvtag(tlb_wvtag), .tlb_wptag(tlb_wptag), .tlb_wnc(tlb_wnc), .tlb_wvalid(tlb_wvalid)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DTLB array the controller drives: registered lookup, writes land at the edge
    logic [TAG_W-1:0] a_vt[EN], a_pt[EN];
    logic             a_v[EN], a_nc[EN];
    logic [IDX_W:0]   a_f;
    always_comb begin
        a_f = '0;
        for (int i = EN - 1; i >= 0; i--)
            if (a_v[i] === 1'b1 && a_vt[i] == tlb_vtag) a_f = {1'b1, IDX_W'(i)};
    end
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < EN; i++) a_v[i] <= 1'b0;
        end else if (tlb_we) begin
            a_v[tlb_widx]  <= tlb_wvalid;
            a_vt[tlb_widx] <= tlb_wvtag;
            a_pt[tlb_widx] <= tlb_wptag;
            a_nc[tlb_widx] <= tlb_wnc;
        end
        tlb_hit     <= tlb_en && a_f[IDX_W];
        tlb_hit_idx <= (tlb_en && a_f[IDX_W]) ? a_f[IDX_W-1:0] : '0;
        tlb_ptag    <= (tlb_en && a_f[IDX_W]) ? a_pt[a_f[IDX_W-1:0]] : '0;
        tlb_nc      <= (tlb_en && a_f[IDX_W]) ? a_nc[a_f[IDX_W-1:0]] : 1'b0;
    end

    // Reference model: TLB contents as the bench believes them, plus expected traffic
    logic [TAG_W-1:0] m_vt[EN], m_pt[EN];
    logic             m_v[EN], m_nc[EN];

    typedef struct {int cyc; logic [IDX_W-1:0] idx; logic valid; logic [TAG_W-1:0] vt, pt; logic nc;} wr_t;
    typedef struct {int cyc; logic [TAG_W-1:0] pt; logic nc, miss;} hw_t;
    typedef struct {int cyc; logic hit; logic [IDX_W-1:0] idx;} sw_t;
    wr_t wq[$];
    hw_t hq[$];
    sw_t sq[$];

    int n_chk = 0, n_fail = 0;
    int flush_end = 0, fgrant = -1, wait_cnt = 0;
    logic sw_taken = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d act=0x%0h exp=0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [IDX_W:0] m_find(input logic [TAG_W-1:0] vt);
        for (int i = 0; i < EN; i++)
            if (m_v[i] && m_vt[i] == vt) return {1'b1, IDX_W'(i)};
        return '0;
    endfunction

    task automatic chk_quiet(input string name);
        chk({name, "_ptag"}, 32'(hw_ptag), 32'd0);
        chk({name, "_wtags"}, 32'(tlb_wvtag | tlb_wptag | tlb_vtag), 32'd0);
        chk({name, "_ctl"}, 32'({hw_gnt, hw_done, hw_nc, hw_miss, sw_gnt, sw_done, sw_probe_hit,
                                  sw_probe_idx, tlb_en, tlb_we, tlb_widx, tlb_wnc, tlb_wvalid}), 32'd0);
    endtask

    // One clock of stimulus: judge grants against the model at the falling edge,
    // queue the responses they imply, then step to just after the next rising edge.
    task automatic tick(input bit quiet = 1'b0);
        logic eh, es, een, idle;
        logic [IDX_W:0] f;
        sw_taken = 1'b0;
        @(negedge clk);
        if (quiet || rst) chk_quiet(rst ? "in_reset" : "after_reset");
        if (!rst) begin
            idle = (cyc >= flush_end);
            eh = idle && hw_req && !(sw_req && wait_cnt >= SMAX);
            es = idle && sw_req && !eh;
            chk("hw_gnt", 32'(hw_gnt), 32'(eh));
            chk("sw_gnt", 32'(sw_gnt), 32'(es));
            een = (eh && on) || (es && sw_op == 2'b01);
            chk("tlb_en", 32'(tlb_en), 32'(een));
            if (een) chk("tlb_vtag", 32'(tlb_vtag), 32'(eh ? hw_vtag : sw_vtag));
            if (eh) begin
                if (on) begin
                    f = m_find(hw_vtag);
                    if (f[IDX_W]) hq.push_back('{cyc + 1, m_pt[f[IDX_W-1:0]], m_nc[f[IDX_W-1:0]], 1'b0});
                    else          hq.push_back('{cyc + 1, '0, 1'b0, 1'b1});
                end else begin
                    hq.push_back('{cyc + 1, hw_vtag, 1'b0, 1'b0});
                end
            end
            if (es) begin
                case (sw_op)
                    2'b00: begin
                        m_v[sw_idx] = 1'b1; m_vt[sw_idx] = sw_vtag;
                        m_pt[sw_idx] = sw_ptag; m_nc[sw_idx] = sw_nc;
                        wq.push_back('{cyc, sw_idx, 1'b1, sw_vtag, sw_ptag, sw_nc});
                        sq.push_back('{cyc + 1, 1'b0, '0});
                    end
                    2'b01: begin
                        f = m_find(sw_vtag);
                        sq.push_back('{cyc + 1, f[IDX_W], f[IDX_W-1:0]});
                    end
                    2'b10: begin
                        fgrant = cyc;
                        flush_end = cyc + EN;
                        for (int i = 0; i < EN; i++) wq.push_back('{cyc + i, IDX_W'(i), 1'b0, '0, '0, 1'b0});
                        sq.push_back('{cyc + EN, 1'b0, '0});
                    end
                    default: sq.push_back('{cyc + 1, 1'b0, '0});
                endcase
            end
            if (fgrant >= 0 && cyc >= fgrant && cyc < flush_end) m_v[cyc - fgrant] = 1'b0;
            wait_cnt = (sw_req && !es) ? ((wait_cnt < SMAX) ? wait_cnt + 1 : SMAX) : 0;
            sw_taken = es;
        end
        @(posedge clk);
        #1;
        if (sw_taken) sw_req = 1'b0;
    endtask

    // Monitor: every DUT output event must match the head of its queue
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            logic ew, ehd, esd;
            wr_t w; hw_t h; sw_t s;
            ew = (wq.size() > 0 && wq[0].cyc == cyc);
            chk("tlb_we", 32'(tlb_we), 32'(ew));
            if (ew) begin
                w = wq.pop_front();
                if (tlb_we) begin
                    chk("tlb_widx", 32'(tlb_widx), 32'(w.idx));
                    chk("tlb_wvalid", 32'(tlb_wvalid), 32'(w.valid));
                    if (w.valid) begin
                        chk("tlb_wvtag", 32'(tlb_wvtag), 32'(w.vt));
                        chk("tlb_wptag", 32'(tlb_wptag), 32'(w.pt));
                        chk("tlb_wnc", 32'(tlb_wnc), 32'(w.nc));
                    end
                end
            end
            ehd = (hq.size() > 0 && hq[0].cyc == cyc);
            chk("hw_done", 32'(hw_done), 32'(ehd));
            if (ehd) begin
                h = hq.pop_front();
                chk("hw_ptag", 32'(hw_ptag), 32'(h.pt));
                chk("hw_nc", 32'(hw_nc), 32'(h.nc));
                chk("hw_miss", 32'(hw_miss), 32'(h.miss));
            end else begin
                chk("hw_idle_res", 32'({hw_ptag, hw_nc, hw_miss}), 32'd0);
            end
            esd = (sq.size() > 0 && sq[0].cyc == cyc);
            chk("sw_done", 32'(sw_done), 32'(esd));
            if (esd) begin
                s = sq.pop_front();
                chk("sw_probe_hit", 32'(sw_probe_hit), 32'(s.hit));
                chk("sw_probe_idx", 32'(sw_probe_idx), 32'(s.idx));
            end else begin
                chk("sw_idle_res", 32'({sw_probe_hit, sw_probe_idx}), 32'd0);
            end
        end
    end

    task automatic run_sw(input logic [1:0] op, input logic [IDX_W-1:0] idx,
                          input logic [TAG_W-1:0] vt, input logic [TAG_W-1:0] pt, input logic nc);
        int n;
        sw_op = op; sw_idx = idx; sw_vtag = vt; sw_ptag = pt; sw_nc = nc; sw_req = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!sw_taken && n < 40);
        chk("sw_grant_bound", 32'(sw_taken), 32'd1);
        sw_req = 1'b0;
    endtask

    function automatic logic [TAG_W-1:0] rnd_tag(input logic [IDX_W-1:0] idx);
        return (TAG_W'($urandom) & ~TAG_W'(EN - 1)) | TAG_W'(idx);
    endfunction

    task automatic fill_all();
        for (int i = 0; i < EN; i++)
            run_sw(2'b00, IDX_W'(i), rnd_tag(IDX_W'(i)), TAG_W'($urandom), 1'($urandom));
    endtask

    initial begin
        int n;
        on = 1'b0; hw_req = 1'b0; hw_vtag = '0;
        sw_req = 1'b0; sw_op = 2'b11; sw_idx = '0; sw_vtag = '0; sw_ptag = '0; sw_nc = 1'b0;
        for (int i = 0; i < EN; i++) begin m_v[i] = 1'b0; m_vt[i] = '0; m_pt[i] = '0; m_nc[i] = 1'b0; end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tick();
        rst = 1'b0;
        tick(1'b1);

        // mapped lookup of a freshly written entry
        run_sw(2'b00, 3'd2, 20'h12345, 20'hABCDE, 1'b1);
        on = 1'b1; hw_req = 1'b1; hw_vtag = 20'h12345;
        tick();
        hw_req = 1'b0;
        repeat (2) tick();

        // bypass, back to back
        on = 1'b0; hw_req = 1'b1;
        for (int v = 1; v <= 3; v++) begin hw_vtag = TAG_W'(v); tick(); end
        hw_req = 1'b0;
        repeat (2) tick();

        // starvation guard against a continuous hw stream
        on = 1'b1;
        run_sw(2'b00, 3'd5, 20'h5A5A5, 20'h0F0F5, 1'b0);
        hw_req = 1'b1; hw_vtag = 20'h12345;
        sw_op = 2'b01; sw_vtag = 20'h5A5A5; sw_req = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!sw_taken && n < 30);
        chk("starve_wait", 32'(n), 32'd9);
        sw_req = 1'b0; hw_req = 1'b0;
        repeat (2) tick();

        // randomized mix
        repeat (600) begin
            logic [IDX_W-1:0] ri;
            ri = IDX_W'($urandom);
            hw_req = ($urandom_range(0, 99) < 60);
            on = ($urandom_range(0, 4) != 0);
            hw_vtag = ($urandom_range(0, 1) == 1) ? m_vt[ri] : TAG_W'($urandom);
            if (!sw_req && $urandom_range(0, 3) == 0) begin
                int r;
                r = $urandom_range(0, 19);
                ri = IDX_W'($urandom);
                sw_idx = ri; sw_nc = 1'($urandom); sw_ptag = TAG_W'($urandom);
                if (r == 0)       begin sw_op = 2'b10; sw_vtag = '0; end
                else if (r < 10)  begin sw_op = 2'b00; sw_vtag = rnd_tag(ri); end
                else if (r < 16)  begin sw_op = 2'b01; sw_vtag = ($urandom_range(0, 9) < 7) ? m_vt[ri] : TAG_W'($urandom); end
                else              begin sw_op = 2'b11; sw_vtag = '0; end
                sw_req = 1'b1;
            end
            tick();
        end
        hw_req = 1'b0; sw_req = 1'b0;
        repeat (EN + 2) tick();

        // flush with hw pressure; entry 4 must miss afterwards
        on = 1'b1;
        fill_all();
        hw_req = 1'b1; hw_vtag = m_vt[4];
        sw_op = 2'b10; sw_req = 1'b1;
        repeat (EN + 12) tick();
        hw_req = 1'b0;
        repeat (2) tick();

        // reset while the walk is at index 3
        fill_all();
        run_sw(2'b10, '0, '0, '0, 1'b0);
        repeat (2) tick();
        rst = 1'b1;
        wq.delete(); hq.delete(); sq.delete();
        flush_end = 0; fgrant = -1; wait_cnt = 0;
        tick();
        rst = 1'b0;
        tick(1'b1);
        hw_req = 1'b1; hw_vtag = m_vt[3];
        tick();
        hw_vtag = m_vt[1];
        tick();
        hw_req = 1'b0;
        repeat (3) tick();

        chk("hw_queue_drained", 32'(hq.size()), 32'd0);
        chk("sw_queue_drained", 32'(sq.size()), 32'd0);
        chk("wr_queue_drained", 32'(wq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
